// File: rtl/int_multiply_pipe.sv
// int_multiply_pipe
//   Multi-lane pipelined signed multiplier with valid/ready on both sides.
//   Stage 0 forms the full-width products, the last stage rescales
//   (arithmetic right shift by SHIFT) and narrows each lane to OUT_WIDTH.
//   Fully stallable: a stage advances when the stage after it is empty or
//   advancing, so bubbles collapse and full throughput is one beat/cycle.
//   Build option: define INT_MULTIPLY_PIPE_ROUND_SAT_EN to round half up
//   before the shift and saturate on narrowing instead of truncating and
//   wrapping. Latency, handshake and ports are the same in both builds.
module int_multiply_pipe #(
  parameter int A_WIDTH     = 8,
  parameter int B_WIDTH     = 8,
  parameter int NUM_LANES   = 4,
  parameter int PIPE_STAGES = 2,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT       = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_LANES-1:0][A_WIDTH-1:0]    data_in_a,
  input  logic [NUM_LANES-1:0][B_WIDTH-1:0]    data_in_b,
  input  logic                                 data_in_valid,
  output logic                                 data_in_ready,
  output logic [NUM_LANES-1:0][OUT_WIDTH-1:0]  data_out,
  output logic                                 data_out_valid,
  input  logic                                 data_out_ready,
  output logic [$clog2(PIPE_STAGES+1)-1:0]     occupancy
);

  localparam int P     = A_WIDTH + B_WIDTH;
  localparam int LAST  = PIPE_STAGES - 1;
  localparam int OCC_W = $clog2(PIPE_STAGES + 1);

  typedef logic [NUM_LANES-1:0][P-1:0] prod_t;

`ifdef INT_MULTIPLY_PIPE_ROUND_SAT_EN
  // Rounding bias (half an output LSB) and saturation bounds, all in P+1 bits.
  localparam int                RND_SH  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [P:0] RND     = (SHIFT > 0) ? ((P+1)'(1) << RND_SH) : '0;
  localparam logic signed [P:0] SAT_MAX = {{(P - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [P:0] SAT_MIN = ~SAT_MAX;
`endif

  logic [PIPE_STAGES-1:0]              v;       // stage holds a beat
  logic [PIPE_STAGES-1:0]              adv;     // stage may take a new beat / hand its beat on
  logic [PIPE_STAGES-1:0]              up_v;    // a beat is offered to the stage from upstream
  prod_t                               prod_in;
  prod_t                               last_in; // product feeding the last stage
  logic [NUM_LANES-1:0][OUT_WIDTH-1:0] out_q;
  logic                                in_fire;
  logic                                out_fire;

  // Rescale one full-width product and narrow it to the output width.
  function automatic logic [OUT_WIDTH-1:0] rescale(input logic [P-1:0] p);
`ifdef INT_MULTIPLY_PIPE_ROUND_SAT_EN
    logic signed [P:0] s;
    s = $signed({p[P-1], p}) + RND;
    s = s >>> SHIFT;
    if (s > SAT_MAX)      s = SAT_MAX;
    else if (s < SAT_MIN) s = SAT_MIN;
    return s[OUT_WIDTH-1:0];
`else
    logic signed [P-1:0] r;
    r = $signed(p) >>> SHIFT;
    return r[OUT_WIDTH-1:0];
`endif
  endfunction

  // Full signed products: sign-extend both operands to P bits, keep the low P bits.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      prod_in[i] = {{B_WIDTH{data_in_a[i][A_WIDTH-1]}}, data_in_a[i]} *
                   {{A_WIDTH{data_in_b[i][B_WIDTH-1]}}, data_in_b[i]};
    end
  end

  // Backward ready chain, from the output towards the input.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    logic go;
    adv = '0;
    go  = !v[LAST] || data_out_ready;
    for (int k = LAST; k >= 0; k--) begin
      if (k < LAST) go = !v[k] || go;
      adv[k] = go;
    end
  end

  // Valid offered to each stage by its upstream neighbour.
  always_comb begin
    up_v    = '0;
    up_v[0] = data_in_valid;
    for (int k = 1; k < PIPE_STAGES; k++) up_v[k] = v[k-1];
  end

  assign data_in_ready  = adv[0];
  assign in_fire        = data_in_valid && data_in_ready;
  assign out_fire       = v[LAST] && data_out_ready;
  assign data_out       = out_q;
  assign data_out_valid = v[LAST];

  // Stage valid bits: take upstream valid whenever the stage advances.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (adv[k]) v[k] <= up_v[k];
      end
    end
  end

  generate
    if (PIPE_STAGES == 1) begin : g_direct
      assign last_in = prod_in;
    end else begin : g_regs
      prod_t prod_q [PIPE_STAGES-1];

      // Product stages 0..LAST-1 load only when a valid beat advances into them.
      // NOTE: these data registers are reset because the zero state is visible after reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < PIPE_STAGES - 1; k++) prod_q[k] <= '0;
        end else begin
          if (adv[0] && up_v[0]) prod_q[0] <= prod_in;
          for (int k = 1; k < LAST; k++) begin
            if (adv[k] && up_v[k]) prod_q[k] <= prod_q[k-1];
          end
        end
      end

      assign last_in = prod_q[LAST-1];
    end
  endgenerate

  // Last stage: rescale and narrow each lane as the beat enters it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (adv[LAST] && up_v[LAST]) begin
      for (int i = 0; i < NUM_LANES; i++) out_q[i] <= rescale(last_in[i]);
    end
  end

  // Beats held in the pipe: +1 on input transfer, -1 on output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (in_fire && !out_fire) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (out_fire && !in_fire) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

endmodule

// File: tb/tb_int_multiply_pipe.sv
// tb_int_multiply_pipe
//   Directed bench for int_multiply_pipe: a default instance (16-bit out,
//   no shift) and a narrow instance (8-bit out, SHIFT=4) share the stimulus.
//   Expected narrow-instance values follow INT_MULTIPLY_PIPE_ROUND_SAT_EN.
module tb_int_multiply_pipe;

  localparam int NL  = 4;
  localparam int AW  = 8;
  localparam int BW  = 8;
  localparam int PS  = 2;
  localparam int OW  = 16;
  localparam int OWS = 8;
  localparam int SH  = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NL-1:0][AW-1:0]  a;
  logic [NL-1:0][BW-1:0]  b;
  logic                   in_valid;
  logic                   out_ready;
  logic                   in_ready,   out_valid;
  logic [NL-1:0][OW-1:0]  dout;
  logic [1:0]             occ;
  logic                   in_ready_s, out_valid_s;
  logic [NL-1:0][OWS-1:0] dout_s;
  logic [1:0]             occ_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_multiply_pipe #(
    .A_WIDTH(AW), .B_WIDTH(BW), .NUM_LANES(NL), .PIPE_STAGES(PS), .OUT_WIDTH(OW), .SHIFT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in_a(a), .data_in_b(b),
    .data_in_valid(in_valid), .data_in_ready(in_ready),
    .data_out(dout), .data_out_valid(out_valid), .data_out_ready(out_ready),
    .occupancy(occ)
  );

  int_multiply_pipe #(
    .A_WIDTH(AW), .B_WIDTH(BW), .NUM_LANES(NL), .PIPE_STAGES(PS), .OUT_WIDTH(OWS), .SHIFT(SH)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .data_in_a(a), .data_in_b(b),
    .data_in_valid(in_valid), .data_in_ready(in_ready_s),
    .data_out(dout_s), .data_out_valid(out_valid_s), .data_out_ready(out_ready),
    .occupancy(occ_s)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint lane(input int i);
    logic signed [OW-1:0] t;
    t = dout[i];
    return longint'(t);
  endfunction

  function automatic longint lane_s(input int i);
    logic signed [OWS-1:0] t;
    t = dout_s[i];
    return longint'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_lanes(input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3);
    a[0] = a0[7:0]; a[1] = a1[7:0]; a[2] = a2[7:0]; a[3] = a3[7:0];
    b[0] = b0[7:0]; b[1] = b1[7:0]; b[2] = b2[7:0]; b[3] = b3[7:0];
  endtask

  // Streaming beat n uses m = n+1: lanes (m*3), (-m*m), (-2*(m+1)), (2*-m).
  task automatic drive_beat(input int n);
    int m;
    m = n + 1;
    set_lanes(m, -m, m + 1, 2, 3, m, -2, -m);
  endtask

  function automatic longint beat_exp(input int n, input int i);
    longint m;
    m = longint'(n + 1);
    case (i)
      0:       return 3 * m;
      1:       return -(m * m);
      2:       return -2 * (m + 1);
      default: return -2 * m;
    endcase
  endfunction

  // Watchdog: every loop below is bounded, this only catches a stuck simulator.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NL*OW-1:0] q[$];
    logic [NL*OW-1:0] e;
    logic [NL*OW-1:0] prev;
    logic [NL-1:0][OW-1:0] held;
    logic hold;
    logic fire;
    int in_idx, out_idx, gaps, sent, got;

    // ---- Reset state ----
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #12;
    check("rst_valid", longint'(out_valid), 0);
    check("rst_data",  longint'(dout), 0);
    check("rst_occ",   longint'(occ), 0);
    check("rst_ready", longint'(in_ready), 1);
    #10 rst_n = 1'b1;
    tick();

    // ---- Extreme operands, latency of exactly PIPE_STAGES ----
    set_lanes(-128, 127, 5, -3, -128, -128, 7, 3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("t1_valid_c1", longint'(out_valid), 0);
    check("t1_occ_c1",   longint'(occ), 1);
    tick();
    check("t1_valid_c2", longint'(out_valid), 1);
    check("t1_lane0",    lane(0), 16384);
    check("t1_lane1",    lane(1), -16256);
    check("t1_lane2",    lane(2), 35);
    check("t1_lane3",    lane(3), -9);
    tick();
    check("t1_valid_c3", longint'(out_valid), 0);
    check("t1_occ_c3",   longint'(occ), 0);

    // ---- Rescale / narrowing: rounding and overflow lanes ----
    set_lanes(7, -8, 127, -128, 9, 1, 127, 127);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t2_valid",   longint'(out_valid), 1);
    check("t2_valid_s", longint'(out_valid_s), 1);
    check("t2_lane0",   lane(0), 63);
    check("t2_lane1",   lane(1), -8);
    check("t2_lane2",   lane(2), 16129);
    check("t2_lane3",   lane(3), -16256);
`ifdef INT_MULTIPLY_PIPE_ROUND_SAT_EN
    check("t2_s_lane0", lane_s(0), 4);
    check("t2_s_lane1", lane_s(1), 0);
    check("t3_s_lane2", lane_s(2), 127);
    check("t3_s_lane3", lane_s(3), -128);
`else
    check("t2_s_lane0", lane_s(0), 3);
    check("t2_s_lane1", lane_s(1), -1);
    check("t3_s_lane2", lane_s(2), -16);
    check("t3_s_lane3", lane_s(3), 8);
`endif
    tick();

    // ---- Stream 10 beats, output stalled for the first 5 cycles ----
    in_idx = 0; out_idx = 0; gaps = 0; held = '0;
    for (int c = 0; c < 60 && out_idx < 10; c++) begin
      out_ready = (c >= 5);
      in_valid  = (in_idx < 10);
      drive_beat(in_idx);
      #1;
      if (c == 2) held = dout;
      if (c == 4) begin
        check("t4_ready_low", longint'(in_ready), 0);
        check("t4_occ_full",  longint'(occ), PS);
        check("t4_accepted",  longint'(in_idx), PS);
        check("t4_valid",     longint'(out_valid), 1);
        check("t4_stable",    longint'(dout), longint'(held));
        check("t4_head",      lane(0), beat_exp(0, 0));
      end
      if (out_valid && out_ready) begin
        for (int i = 0; i < NL; i++) check($sformatf("t4_beat%0d_lane%0d", out_idx, i), lane(i), beat_exp(out_idx, i));
        out_idx++;
      end else if (c >= 5) begin
        gaps++;
      end
      fire = in_valid && in_ready;
      tick();
      if (fire) in_idx++;
    end
    in_valid = 1'b0;
    check("t4_out_count", longint'(out_idx), 10);
    check("t4_gaps",      longint'(gaps), 0);

    // ---- Random valid/ready toggling against a scoreboard ----
    sent = 0; got = 0; hold = 1'b0; prev = '0;
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = $urandom;
      b = $urandom;
      #1;
      check("t5_occ", longint'(occ), longint'(sent - got));
      if (hold) check("t5_hold", longint'(dout), longint'(prev));
      if (in_valid && in_ready) begin
        for (int i = 0; i < NL; i++) begin
          logic signed [AW-1:0] sa;
          logic signed [BW-1:0] sb;
          int p;
          sa = a[i];
          sb = b[i];
          p  = sa * sb;
          e[i*OW +: OW] = p[OW-1:0];
        end
        q.push_back(e);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("t5_spurious", 1, 0);
        end else begin
          e = q.pop_front();
          check("t5_data", longint'(dout), longint'(e));
        end
        got++;
      end
      hold = out_valid && !out_ready;
      prev = dout;
      tick();
    end
    in_valid = 1'b0;
    check("t5_count", longint'(got), 1000);
    check("t5_sent",  longint'(sent), 1000);

    // ---- Reset with two beats in flight ----
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_beat(0);
    tick();
    drive_beat(1);
    tick();
    in_valid = 1'b0;
    #1;
    check("t6_pre_occ", longint'(occ), 2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", longint'(out_valid), 0);
    check("t6_rst_occ",   longint'(occ), 0);
    check("t6_rst_data",  longint'(dout), 0);
    check("t6_rst_ready", longint'(in_ready), 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive_beat(2);
    tick();
    in_valid = 1'b0;
    check("t6_c1_valid", longint'(out_valid), 0);
    tick();
    check("t6_c2_valid", longint'(out_valid), 1);
    check("t6_c2_lane0", lane(0), beat_exp(2, 0));
    check("t6_c2_lane1", lane(1), beat_exp(2, 1));
    tick();
    check("t6_c3_valid", longint'(out_valid), 0);
    check("t6_c3_occ",   longint'(occ), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
